width_gearbox: RTL and testbench
================================

Name: width_gearbox

Overview:
- Parametrised streaming width converter from an input word of WIDTH_IN bits to an output word of WIDTH_OUT bits.
- Down-converts (serialises) when WIDTH_IN > WIDTH_OUT and up-converts (packs) when WIDTH_IN < WIDTH_OUT, using valid/ready handshakes on both sides.
- Supports selectable beat order and packet-end flush with zero padding.
- Sits between narrow peripheral ports and wider datapath buses.

Parameters:
- WIDTH_IN, 8, input data width in bits.
- WIDTH_OUT, 4, output data width in bits; the larger of WIDTH_IN/WIDTH_OUT must be an integer multiple of the smaller.
- LSB_FIRST, 1, 1 = least-significant chunk is first in time; 0 = most-significant chunk first.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH_IN  input word.
- in_valid  input  1  in_data qualified.
- in_last  input  1  final word of packet; qualified by in_valid.
- in_ready  output  1  block accepts the input word this cycle.
- out_data  output  WIDTH_OUT  output word.
- out_valid  output  1  out_data qualified.
- out_last  output  1  final output word of packet.
- out_ready  input  1  sink accepts the output word this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, out_valid=0, out_last=0, out_data=0, in_ready=0. Beat counter and holding register are cleared. Reset mid-packet discards partial data with no flush. in_ready rises on the first clock edge after rst_n deasserts.
- Handshake: a transfer occurs on a rising edge where valid && ready. out_data and out_last stay stable while out_valid=1 && out_ready=0. out_valid never drops without a transfer.
- RATIO = max(WIDTH_IN,WIDTH_OUT)/min(WIDTH_IN,WIDTH_OUT). CW = clog2(RATIO), minimum 1.
- Equal widths: registered pass-through stage with 1-cycle latency, full throughput. in_ready = !out_valid || out_ready.
- Down mode, states IDLE and SHIFT:
  - IDLE: in_ready=1. An accept loads the holding register, sets cnt=0 and out_valid=1, then goes to SHIFT.
  - SHIFT: out_data = chunk[cnt], where chunk 0 is bits [WIDTH_OUT-1:0] if LSB_FIRST=1, else the top chunk.
  - Each out transfer increments cnt.
  - On the transfer of chunk RATIO-1: out_last = registered in_last. in_ready=1 combinationally when out_ready=1, so back-to-back words stream with no bubble. With no new input, return to IDLE.
  - Latency: 1 cycle from input accept to first out_valid. Throughput: one input every RATIO cycles.
- Up mode, states FILL and FULL:
  - FILL: in_ready=1. Each accept writes in_data into slot cnt (slot order per LSB_FIRST) and increments cnt.
  - When cnt reaches RATIO-1, or in_last=1 is accepted: out_valid=1, out_last=in_last, go to FULL. Unfilled slots are zero.
  - FULL: in_ready = out_ready, so a simultaneous output transfer and input accept starts a new word in slot 0 with no bubble. Otherwise, on the out transfer, go to FILL with cnt=0.
  - Latency: out_valid is asserted 1 cycle after the accept of the final input beat.
- Wrap-around: cnt wraps RATIO-1 -> 0 only on a completed word, never on a stall.
- Elaboration-time error if the widths are not integer multiples of each other or either is 0.

Decomposition:
- Shared package gearbox_pkg holds:
  - clog2 helper function.
  - Localparam computation of RATIO and CW.
  - Mode enum MODE_PASS / MODE_DOWN / MODE_UP.
  - State encodings for both FSMs.
- One sub-module, gearbox_beat_ctr: CW-bit counter with inc, clear and terminal-count (== RATIO-1) output, asynchronous active-low reset. Instantiated once in either mode.
- Mode selection is by generate on the mode value, with no runtime mode port.

Test Plan:
- Down, 8->4, LSB_FIRST=1: in 0xA5 then 0x3C, out_ready=1 -> out 0x5, 0xA, 0xC, 0x3 on consecutive cycles, in_ready never deasserts between words.
- Down, 8->4, LSB_FIRST=0, out_ready held 0 for 3 cycles after first out_valid -> out_data holds 0xA, then 0x5; second input stalls (in_ready=0) until the final chunk transfers.
- Up, 4->16, LSB_FIRST=1: in 0x1, 0x2, 0x3, 0x4 -> single out 0x4321, out_valid exactly 1 cycle after the 4th accept.
- Up, 4->16, in 0xF, 0xE with in_last on 0xE -> out 0x00EF with out_last=1. Next packet 0x1..0x4 gives 0x4321 with out_last=0.
- Up, 4->8, continuous in_valid and out_ready -> one output every 2 cycles, no dropped or duplicated beats over 1000 random words (scoreboard).
- Reset mid-operation: 8->4, assert rst_n=0 asynchronously after the first chunk -> out_valid falls immediately. After release, input 0x77 -> out 0x7, 0x7 only, with no stale chunk.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared types and elaboration helpers for the width gearbox.
// Ratio, counter width and mode are derived here from the two data widths.
package gearbox_pkg;

    typedef enum logic [1:0] {MODE_PASS, MODE_DOWN, MODE_UP} mode_t;
    typedef enum logic {DN_IDLE, DN_SHIFT} down_state_t;
    typedef enum logic {UP_FILL, UP_FULL} up_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic bit widths_ok(input int wi, input int wo);
        if (wi <= 0 || wo <= 0) return 1'b0;
        return (wi > wo) ? ((wi % wo) == 0) : ((wo % wi) == 0);
    endfunction

    function automatic int calc_ratio(input int wi, input int wo);
        if (wi <= 0 || wo <= 0) return 1;
        return (wi > wo) ? (wi / wo) : (wo / wi);
    endfunction

    function automatic int calc_cw(input int ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

    function automatic mode_t calc_mode(input int wi, input int wo);
        if (wi > wo) return MODE_DOWN;
        if (wi < wo) return MODE_UP;
        return MODE_PASS;
    endfunction

endpackage

// File: rtl/gearbox_beat_ctr.sv
// Beat counter: tracks the chunk/slot index within one wide word.
// Latency: registered count, terminal count is combinational from it.
// Backpressure: none; advances only when inc is asserted, clr has priority.
module gearbox_beat_ctr
    import gearbox_pkg::*;
#(
    parameter int RATIO = 2,
    parameter int CW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/width_gearbox.sv
// Streaming width converter: serialises wide words or packs narrow beats.
// Latency: 1 cycle from the (final) input accept to out_valid in every mode.
// Backpressure: output held stable while out_ready=0; in_ready drops until the word drains.
module width_gearbox
    import gearbox_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int    RATIO = calc_ratio(WIDTH_IN, WIDTH_OUT);
    localparam int    CW    = calc_cw(RATIO);
    localparam mode_t MODE  = calc_mode(WIDTH_IN, WIDTH_OUT);

    if (!widths_ok(WIDTH_IN, WIDTH_OUT)) begin : g_bad_width
        $error("width_gearbox: WIDTH_IN=%0d and WIDTH_OUT=%0d are not integer multiples", WIDTH_IN, WIDTH_OUT);
    end

    // Holds in_ready low until the first edge after reset release.
    logic en_q;
    logic in_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= 1'b1;
    end

    assign in_fire = in_valid & in_ready;

    if (MODE == MODE_PASS) begin : g_pass
        logic [WIDTH_OUT-1:0] data_q;
        logic                 last_q;
        logic                 vld_q;

        assign in_ready  = en_q & (~vld_q | out_ready);
        assign out_data  = data_q;
        assign out_valid = vld_q;
        assign out_last  = vld_q & last_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                last_q <= 1'b0;
                vld_q  <= 1'b0;
            end else if (in_fire) begin
                data_q <= in_data;
                last_q <= in_last;
                vld_q  <= 1'b1;
            end else if (out_ready) begin
                vld_q  <= 1'b0;
            end
        end

    end else if (MODE == MODE_DOWN) begin : g_down
        localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

        down_state_t          state_q, state_d;
        logic [WIDTH_IN-1:0]  hold_q;
        logic                 last_q;
        logic [CW-1:0]        cnt;
        logic [CW-1:0]        idx;
        logic                 tc, inc, clr;

        gearbox_beat_ctr #(.RATIO(RATIO), .CW(CW)) u_ctr (
            .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .cnt(cnt), .tc(tc)
        );

        assign idx = (LSB_FIRST != 0) ? cnt : LAST - cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= DN_IDLE;
            else        state_q <= state_d;
        end

        always_comb begin
            state_d   = state_q;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            out_last  = 1'b0;
            inc       = 1'b0;
            clr       = 1'b0;
            case (state_q)
                DN_IDLE: begin
                    in_ready = en_q;
                    if (in_valid && en_q) begin
                        state_d = DN_SHIFT;
                        clr     = 1'b1;
                    end
                end
                DN_SHIFT: begin
                    out_valid = 1'b1;
                    out_data  = hold_q[int'(idx)*WIDTH_OUT +: WIDTH_OUT];
                    out_last  = tc & last_q;
                    // Accept the next word on the final chunk so words stream without a bubble.
                    in_ready  = en_q & tc & out_ready;
                    if (out_ready) begin
                        if (!tc) begin
                            inc = 1'b1;
                        end else begin
                            clr = 1'b1;
                            if (!(in_valid && en_q)) state_d = DN_IDLE;
                        end
                    end
                end
                default: state_d = DN_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
                last_q <= 1'b0;
            end else if (in_fire) begin
                hold_q <= in_data;
                last_q <= in_last;
            end
        end

    end else begin : g_up
        localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

        up_state_t            state_q, state_d;
        logic [WIDTH_OUT-1:0] hold_q, hold_d;
        logic                 last_q;
        logic [CW-1:0]        cnt;
        logic [CW-1:0]        slot;
        logic                 tc, inc, clr, done;

        gearbox_beat_ctr #(.RATIO(RATIO), .CW(CW)) u_ctr (
            .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .cnt(cnt), .tc(tc)
        );

        assign slot      = (LSB_FIRST != 0) ? cnt : LAST - cnt;
        assign done      = tc | in_last;
        assign out_data  = hold_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= UP_FILL;
            else        state_q <= state_d;
        end

        always_comb begin
            state_d   = state_q;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            inc       = 1'b0;
            clr       = 1'b0;
            if (state_q == UP_FULL) begin
                out_valid = 1'b1;
                out_last  = last_q;
                in_ready  = en_q & out_ready;
                if (out_ready) state_d = UP_FILL;
            end else begin
                in_ready = en_q;
            end
            if (in_valid && in_ready) begin
                if (done) begin
                    state_d = UP_FULL;
                    clr     = 1'b1;
                end else begin
                    inc     = 1'b1;
                end
            end
        end

        // The first beat of a word starts from zero so a flushed word has empty upper slots.
        always_comb begin
            hold_d = (cnt == '0) ? '0 : hold_q;
            hold_d[int'(slot)*WIDTH_IN +: WIDTH_IN] = in_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
                last_q <= 1'b0;
            end else if (in_fire) begin
                hold_q <= hold_d;
                last_q <= in_last;
            end
        end
    end

endmodule

// File: tb/tb_width_gearbox.sv
// Directed bench for width_gearbox: pass, down (both beat orders), up with flush,
// a random packing scoreboard and an asynchronous reset in mid-word.
module tb_width_gearbox;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 8->4, least-significant chunk first
    logic [7:0]  d1_in_data;  logic d1_in_valid, d1_in_last, d1_in_ready;
    logic [3:0]  d1_out_data; logic d1_out_valid, d1_out_last, d1_out_ready;
    // 8->4, most-significant chunk first
    logic [7:0]  d0_in_data;  logic d0_in_valid, d0_in_last, d0_in_ready;
    logic [3:0]  d0_out_data; logic d0_out_valid, d0_out_last, d0_out_ready;
    // 4->16
    logic [3:0]  u16_in_data;  logic u16_in_valid, u16_in_last, u16_in_ready;
    logic [15:0] u16_out_data; logic u16_out_valid, u16_out_last, u16_out_ready;
    // 4->8
    logic [3:0]  u8_in_data;  logic u8_in_valid, u8_in_last, u8_in_ready;
    logic [7:0]  u8_out_data; logic u8_out_valid, u8_out_last, u8_out_ready;
    // 8->8
    logic [7:0]  p_in_data;  logic p_in_valid, p_in_last, p_in_ready;
    logic [7:0]  p_out_data; logic p_out_valid, p_out_last, p_out_ready;

    width_gearbox #(.WIDTH_IN(8), .WIDTH_OUT(4), .LSB_FIRST(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid), .in_last(d1_in_last),
        .in_ready(d1_in_ready), .out_data(d1_out_data), .out_valid(d1_out_valid), .out_last(d1_out_last),
        .out_ready(d1_out_ready));
    width_gearbox #(.WIDTH_IN(8), .WIDTH_OUT(4), .LSB_FIRST(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid), .in_last(d0_in_last),
        .in_ready(d0_in_ready), .out_data(d0_out_data), .out_valid(d0_out_valid), .out_last(d0_out_last),
        .out_ready(d0_out_ready));
    width_gearbox #(.WIDTH_IN(4), .WIDTH_OUT(16), .LSB_FIRST(1)) u_u16 (
        .clk(clk), .rst_n(rst_n), .in_data(u16_in_data), .in_valid(u16_in_valid), .in_last(u16_in_last),
        .in_ready(u16_in_ready), .out_data(u16_out_data), .out_valid(u16_out_valid), .out_last(u16_out_last),
        .out_ready(u16_out_ready));
    width_gearbox #(.WIDTH_IN(4), .WIDTH_OUT(8), .LSB_FIRST(1)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_data(u8_in_data), .in_valid(u8_in_valid), .in_last(u8_in_last),
        .in_ready(u8_in_ready), .out_data(u8_out_data), .out_valid(u8_out_valid), .out_last(u8_out_last),
        .out_ready(u8_out_ready));
    width_gearbox #(.WIDTH_IN(8), .WIDTH_OUT(8), .LSB_FIRST(1)) u_p (
        .clk(clk), .rst_n(rst_n), .in_data(p_in_data), .in_valid(p_in_valid), .in_last(p_in_last),
        .in_ready(p_in_ready), .out_data(p_out_data), .out_valid(p_out_valid), .out_last(p_out_last),
        .out_ready(p_out_ready));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (d1_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h want 0", d1_out_valid); end
        checks++; if (d1_out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data: got %0h want 0", d1_out_data); end
        checks++; if (d1_out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0h want 0", d1_out_last); end
        checks++; if (d1_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_down: got %0h want 0", d1_in_ready); end
        checks++; if (u16_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_up: got %0h want 0", u16_in_ready); end
        checks++; if (u16_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_up: got %0h want 0", u16_out_valid); end
        checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_pass: got %0h want 0", p_in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (d1_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %0h want 0", d1_in_ready); end
        step();
        checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge: got %0h want 1", d1_in_ready); end
        checks++; if (u8_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge_up: got %0h want 1", u8_in_ready); end
    endtask

    task automatic test_pass();
        p_out_ready = 1'b1; p_in_valid = 1'b1; p_in_data = 8'h5A; p_in_last = 1'b1;
        #1;
        checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready: got %0h want 1", p_in_ready); end
        step();
        p_in_data = 8'hC3; p_in_last = 1'b0;
        #1;
        checks++; if (p_out_valid !== 1'b1 || p_out_data !== 8'h5A || p_out_last !== 1'b1) begin
            errors++; $display("FAIL pass_first: got v=%0h d=%0h l=%0h want v=1 d=5a l=1", p_out_valid, p_out_data, p_out_last); end
        checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL pass_full_rate: got %0h want 1", p_in_ready); end
        step();
        p_in_valid = 1'b0;
        #1;
        checks++; if (p_out_valid !== 1'b1 || p_out_data !== 8'hC3) begin
            errors++; $display("FAIL pass_second: got v=%0h d=%0h want v=1 d=c3", p_out_valid, p_out_data); end
        step();
        checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: got %0h want 0", p_out_valid); end
    endtask

    task automatic test_down_lsb();
        d1_out_ready = 1'b1; d1_in_valid = 1'b1; d1_in_data = 8'hA5; d1_in_last = 1'b0;
        #1;
        checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL dl_ready_idle: got %0h want 1", d1_in_ready); end
        step();
        d1_in_data = 8'h3C; d1_in_last = 1'b1;
        #1;
        checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== 4'h5 || d1_out_last !== 1'b0) begin
            errors++; $display("FAIL dl_chunk0: got v=%0h d=%0h l=%0h want v=1 d=5 l=0", d1_out_valid, d1_out_data, d1_out_last); end
        checks++; if (d1_in_ready !== 1'b0) begin errors++; $display("FAIL dl_ready_mid: got %0h want 0", d1_in_ready); end
        step();
        checks++; if (d1_out_data !== 4'hA || d1_out_last !== 1'b0) begin
            errors++; $display("FAIL dl_chunk1: got d=%0h l=%0h want d=a l=0", d1_out_data, d1_out_last); end
        checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL dl_ready_boundary: got %0h want 1", d1_in_ready); end
        step();
        d1_in_valid = 1'b0;
        #1;
        checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== 4'hC) begin
            errors++; $display("FAIL dl_chunk2: got v=%0h d=%0h want v=1 d=c", d1_out_valid, d1_out_data); end
        step();
        checks++; if (d1_out_data !== 4'h3 || d1_out_last !== 1'b1) begin
            errors++; $display("FAIL dl_chunk3: got d=%0h l=%0h want d=3 l=1", d1_out_data, d1_out_last); end
        step();
        checks++; if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
            errors++; $display("FAIL dl_idle: got v=%0h r=%0h want v=0 r=1", d1_out_valid, d1_in_ready); end
    endtask

    task automatic test_down_msb();
        d0_out_ready = 1'b0; d0_in_valid = 1'b1; d0_in_data = 8'hA5; d0_in_last = 1'b0;
        #1;
        checks++; if (d0_in_ready !== 1'b1) begin errors++; $display("FAIL dm_ready_idle: got %0h want 1", d0_in_ready); end
        step();
        d0_in_data = 8'h3C;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== 4'hA) begin
                errors++; $display("FAIL dm_hold%0d: got v=%0h d=%0h want v=1 d=a", i, d0_out_valid, d0_out_data); end
            checks++; if (d0_in_ready !== 1'b0) begin errors++; $display("FAIL dm_stall%0d: got %0h want 0", i, d0_in_ready); end
            step();
        end
        d0_out_ready = 1'b1;
        #1;
        checks++; if (d0_out_data !== 4'hA || d0_in_ready !== 1'b0) begin
            errors++; $display("FAIL dm_release: got d=%0h r=%0h want d=a r=0", d0_out_data, d0_in_ready); end
        step();
        checks++; if (d0_out_data !== 4'h5 || d0_in_ready !== 1'b1) begin
            errors++; $display("FAIL dm_chunk1: got d=%0h r=%0h want d=5 r=1", d0_out_data, d0_in_ready); end
        step();
        d0_in_valid = 1'b0;
        #1;
        checks++; if (d0_out_valid !== 1'b1 || d0_out_data !== 4'h3) begin
            errors++; $display("FAIL dm_second0: got v=%0h d=%0h want v=1 d=3", d0_out_valid, d0_out_data); end
        step();
        checks++; if (d0_out_data !== 4'hC) begin errors++; $display("FAIL dm_second1: got %0h want c", d0_out_data); end
        step();
        checks++; if (d0_out_valid !== 1'b0) begin errors++; $display("FAIL dm_idle: got %0h want 0", d0_out_valid); end
    endtask

    task automatic test_up_pack();
        u16_out_ready = 1'b1; u16_in_last = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            u16_in_valid = 1'b1; u16_in_data = 4'(i);
            #1;
            checks++; if (u16_in_ready !== 1'b1) begin errors++; $display("FAIL up_ready%0d: got %0h want 1", i, u16_in_ready); end
            checks++; if (u16_out_valid !== 1'b0) begin errors++; $display("FAIL up_early%0d: got %0h want 0", i, u16_out_valid); end
            step();
        end
        u16_in_valid = 1'b0;
        #1;
        checks++; if (u16_out_valid !== 1'b1 || u16_out_data !== 16'h4321 || u16_out_last !== 1'b0) begin
            errors++; $display("FAIL up_word: got v=%0h d=%0h l=%0h want v=1 d=4321 l=0", u16_out_valid, u16_out_data, u16_out_last); end
        step();
        checks++; if (u16_out_valid !== 1'b0) begin errors++; $display("FAIL up_single: got %0h want 0", u16_out_valid); end
    endtask

    task automatic test_up_flush();
        u16_out_ready = 1'b1; u16_in_valid = 1'b1; u16_in_data = 4'hF; u16_in_last = 1'b0;
        step();
        u16_in_data = 4'hE; u16_in_last = 1'b1;
        #1;
        checks++; if (u16_out_valid !== 1'b0) begin errors++; $display("FAIL fl_early: got %0h want 0", u16_out_valid); end
        step();
        u16_in_data = 4'h1; u16_in_last = 1'b0;
        #1;
        checks++; if (u16_out_valid !== 1'b1 || u16_out_data !== 16'h00EF || u16_out_last !== 1'b1) begin
            errors++; $display("FAIL fl_word: got v=%0h d=%0h l=%0h want v=1 d=00ef l=1", u16_out_valid, u16_out_data, u16_out_last); end
        checks++; if (u16_in_ready !== 1'b1) begin errors++; $display("FAIL fl_no_bubble: got %0h want 1", u16_in_ready); end
        step();
        for (int i = 2; i <= 4; i++) begin
            u16_in_data = 4'(i);
            #1;
            checks++; if (u16_out_valid !== 1'b0) begin errors++; $display("FAIL fl_next_early%0d: got %0h want 0", i, u16_out_valid); end
            step();
        end
        u16_in_valid = 1'b0;
        #1;
        checks++; if (u16_out_valid !== 1'b1 || u16_out_data !== 16'h4321 || u16_out_last !== 1'b0) begin
            errors++; $display("FAIL fl_next_word: got v=%0h d=%0h l=%0h want v=1 d=4321 l=0", u16_out_valid, u16_out_data, u16_out_last); end
        step();
    endtask

    task automatic test_up_stream();
        logic [3:0] nib [2000];
        logic [7:0] exp_byte;
        int in_idx, out_idx, stalls, cyc;
        for (int i = 0; i < 2000; i++) nib[i] = 4'($urandom_range(0, 15));
        in_idx = 0; out_idx = 0; stalls = 0; cyc = 0;
        u8_out_ready = 1'b1; u8_in_last = 1'b0;
        while (out_idx < 1000 && cyc < 5000) begin
            u8_in_valid = (in_idx < 2000);
            u8_in_data  = (in_idx < 2000) ? nib[in_idx] : 4'h0;
            #1;
            if (u8_in_valid && !u8_in_ready) stalls++;
            if (u8_out_valid) begin
                exp_byte = {nib[2*out_idx+1], nib[2*out_idx]};
                checks++; if (u8_out_data !== exp_byte) begin
                    errors++; $display("FAIL us_word%0d: got %0h want %0h", out_idx, u8_out_data, exp_byte); end
                out_idx++;
            end
            if (u8_in_valid && u8_in_ready) in_idx++;
            step();
            cyc++;
        end
        u8_in_valid = 1'b0;
        checks++; if (out_idx != 1000) begin errors++; $display("FAIL us_count: got %0d want 1000", out_idx); end
        checks++; if (stalls != 0) begin errors++; $display("FAIL us_stalls: got %0d want 0", stalls); end
        checks++; if (cyc != 2001) begin errors++; $display("FAIL us_cycles: got %0d want 2001", cyc); end
    endtask

    task automatic test_reset_mid();
        int n;
        d1_out_ready = 1'b1; d1_in_valid = 1'b1; d1_in_data = 8'hA5; d1_in_last = 1'b0;
        step();
        d1_in_valid = 1'b0;
        #1;
        checks++; if (d1_out_data !== 4'h5) begin errors++; $display("FAIL rm_chunk0: got %0h want 5", d1_out_data); end
        step();
        #2;
        checks++; if (d1_out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_reset: got %0h want 1", d1_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b0 || d1_out_data !== 4'h0) begin
            errors++; $display("FAIL rm_async: got v=%0h r=%0h d=%0h want v=0 r=0 d=0", d1_out_valid, d1_in_ready, d1_out_data); end
        step();
        rst_n = 1'b1;
        step();
        d1_in_valid = 1'b1; d1_in_data = 8'h77;
        #1;
        checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %0h want 1", d1_in_ready); end
        step();
        d1_in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (d1_out_valid === 1'b1) begin
                checks++; if (d1_out_data !== 4'h7) begin errors++; $display("FAIL rm_data%0d: got %0h want 7", n, d1_out_data); end
                n++;
            end
            step();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL rm_beats: got %0d want 2", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        d1_in_data = '0;  d1_in_valid = 1'b0;  d1_in_last = 1'b0;  d1_out_ready = 1'b0;
        d0_in_data = '0;  d0_in_valid = 1'b0;  d0_in_last = 1'b0;  d0_out_ready = 1'b0;
        u16_in_data = '0; u16_in_valid = 1'b0; u16_in_last = 1'b0; u16_out_ready = 1'b0;
        u8_in_data = '0;  u8_in_valid = 1'b0;  u8_in_last = 1'b0;  u8_out_ready = 1'b0;
        p_in_data = '0;   p_in_valid = 1'b0;   p_in_last = 1'b0;   p_out_ready = 1'b0;
        test_reset();
        test_pass();
        test_down_lsb();
        test_down_msb();
        test_up_pack();
        test_up_flush();
        test_up_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
